// File: rtl/cnn_pool_pkg.sv
// Shared types and geometry helpers for the CNN pooling stages.
// Mode/state enums plus the pooled-row length derived from the input row length.
package cnn_pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } pool_state_e;

  localparam int DEF_ROW_LEN = 24;
  localparam int OUT_LEN     = DEF_ROW_LEN / 2;

  function automatic int out_len(input int row_len);
    return row_len / 2;
  endfunction

endpackage

// File: rtl/pool_window4.sv
// One 2x2 pooling window: signed max or floor-average of four elements.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Purely combinational; the parent registers the result.
module pool_window4
  import cnn_pool_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] p0,
  input  logic signed [DATA_W-1:0] p1,
  input  logic signed [DATA_W-1:0] p2,
  input  logic signed [DATA_W-1:0] p3,
  input  pool_mode_e               mode,
  output logic signed [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] max01;
  logic signed [DATA_W-1:0] max23;
  logic signed [DATA_W-1:0] max_all;
  logic signed [DATA_W+1:0] sum;

  assign max01   = (p0 > p1) ? p0 : p1;
  assign max23   = (p2 > p3) ? p2 : p3;
  assign max_all = (max01 > max23) ? max01 : max23;

  // Two guard bits hold the worst-case sum; >>> 2 floors toward -inf.
  assign sum = {{2{p0[DATA_W-1]}}, p0} + {{2{p1[DATA_W-1]}}, p1}
             + {{2{p2[DATA_W-1]}}, p2} + {{2{p3[DATA_W-1]}}, p3};

  assign result = (mode == POOL_AVG) ? DATA_W'(sum >>> 2) : max_all;

endmodule

// File: rtl/pool2x2_stream.sv
// 2x2/stride-2 row-streaming pooling stage (max/avg), optional ReLU via POOL2X2_RELU_EN.
// Latency: pooled row valid 1 cycle after the odd-row accept.
// Backpressure: even row always accepted; odd row stalls while the output is held and not draining.
module pool2x2_stream
  import cnn_pool_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ROW_LEN    = 24,
  parameter int CH         = 4,
  parameter int FRAME_ROWS = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CH*ROW_LEN*DATA_W-1:0]      in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CH*(ROW_LEN/2)*DATA_W-1:0]  out_data,
  output logic                              pool_end
);

  localparam int OLEN  = out_len(ROW_LEN);
  localparam int IN_W  = CH * ROW_LEN * DATA_W;
  localparam int OUT_W = CH * OLEN * DATA_W;
  localparam int CNT_W = (FRAME_ROWS > 2) ? $clog2(FRAME_ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(FRAME_ROWS - 1);

  if ((ROW_LEN % 2) != 0 || (FRAME_ROWS % 2) != 0 || CH < 1) begin : g_bad_cfg
    $error("pool2x2_stream: ROW_LEN and FRAME_ROWS must be even and CH >= 1");
  end

  pool_state_e      state;
  pool_mode_e       mode_q;
  logic [CNT_W-1:0] row_cnt;
  logic [IN_W-1:0]  row_buf;
  logic [OUT_W-1:0] pooled;
  logic             accept;
  logic             drain;

  assign in_ready = en & ((state == S_EVEN) | ~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  for (genvar ch = 0; ch < CH; ch++) begin : g_ch
    for (genvar k = 0; k < OLEN; k++) begin : g_win
      logic signed [DATA_W-1:0] win_y;

      pool_window4 #(.DATA_W(DATA_W)) u_win (
        .p0     (row_buf[(ch*ROW_LEN + 2*k)     * DATA_W +: DATA_W]),
        .p1     (row_buf[(ch*ROW_LEN + 2*k + 1) * DATA_W +: DATA_W]),
        .p2     (in_data[(ch*ROW_LEN + 2*k)     * DATA_W +: DATA_W]),
        .p3     (in_data[(ch*ROW_LEN + 2*k + 1) * DATA_W +: DATA_W]),
        .mode   (mode_q),
        .result (win_y)
      );

`ifdef POOL2X2_RELU_EN
      assign pooled[(ch*OLEN + k) * DATA_W +: DATA_W] = win_y[DATA_W-1] ? '0 : win_y;
`else
      assign pooled[(ch*OLEN + k) * DATA_W +: DATA_W] = win_y;
`endif
    end
  end

  // Row buffer contents are irrelevant after reset: state S_EVEN always refills it first.
  always_ff @(posedge clk) begin
    if (accept && state == S_EVEN) begin
      row_buf <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_EVEN;
      mode_q    <= POOL_MAX;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      pool_end  <= 1'b0;
    end else begin
      if (drain) begin
        out_valid <= 1'b0;
        pool_end  <= 1'b0;
      end
      if (accept) begin
        row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
        if (state == S_EVEN) begin
          mode_q <= pool_mode_e'(mode);
          state  <= S_ODD;
        end else begin
          out_data  <= pooled;
          out_valid <= 1'b1;
          pool_end  <= (row_cnt == LAST_ROW);
          state     <= S_EVEN;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream with CH=1, ROW_LEN=4, FRAME_ROWS=4, DATA_W=8.
module tb_pool2x2_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        pool_end;

  int checks   = 0;
  int failures = 0;

  pool2x2_stream #(
    .DATA_W(8), .ROW_LEN(4), .CH(1), .FRAME_ROWS(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .pool_end  (pool_end)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] row4(input int e0, input int e1, input int e2, input int e3);
    return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  function automatic logic [15:0] out2(input int k0, input int k1);
    return {k1[7:0], k0[7:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++;
    if (pool_end !== 1'b0) begin failures++; $display("FAIL reset_pool_end got=%0b exp=0", pool_end); end
    checks++;
    if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_max();
    do_reset();
    mode = 1'b0;
    push(row4(1, -2, 3, 4));
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL max_early_valid got=%0b exp=0", out_valid); end
    push(row4(5, 0, -7, 2));
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL max_valid got=%0b exp=1", out_valid); end
    checks++;
    if (out_data !== out2(5, 4)) begin failures++; $display("FAIL max_data got=%h exp=%h", out_data, out2(5, 4)); end
    checks++;
    if (pool_end !== 1'b0) begin failures++; $display("FAIL max_pool_end got=%0b exp=0", pool_end); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL max_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_avg();
    do_reset();
    mode = 1'b1;
    push(row4(1, -2, 3, 4));
    push(row4(5, 0, -7, 2));
    checks++;
    if (out_data !== out2(1, 0)) begin failures++; $display("FAIL avg_basic got=%h exp=%h", out_data, out2(1, 0)); end
    push(row4(-1, -1, -1, -1));
    push(row4(-2, -2, -2, -2));
    checks++;
    if (out_data !== out2(-2, -2)) begin failures++; $display("FAIL avg_floor got=%h exp=%h", out_data, out2(-2, -2)); end
    checks++;
    if (pool_end !== 1'b1) begin failures++; $display("FAIL avg_pool_end got=%0b exp=1", pool_end); end
    push(row4(127, 127, -128, -128));
    push(row4(127, 127, -128, -128));
    checks++;
    if (out_data !== out2(127, -128)) begin failures++; $display("FAIL avg_extreme got=%h exp=%h", out_data, out2(127, -128)); end
    checks++;
    if (pool_end !== 1'b0) begin failures++; $display("FAIL avg_wrap_pool_end got=%0b exp=0", pool_end); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode      = 1'b0;
    out_ready = 1'b0;
    push(row4(1, 2, 3, 4));
    push(row4(0, 0, 0, 0));
    checks++;
    if (out_data !== out2(2, 4)) begin failures++; $display("FAIL bp_first got=%h exp=%h", out_data, out2(2, 4)); end
    push(row4(-5, -6, -7, -8));
    in_data  = row4(-1, -9, 10, -10);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got=%0b exp=0", in_ready); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== out2(2, 4)) begin
      failures++; $display("FAIL bp_hold valid=%0b data=%h exp=1/%h", out_valid, out_data, out2(2, 4));
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== out2(-1, 10)) begin
      failures++; $display("FAIL bp_reload valid=%0b data=%h exp=1/%h", out_valid, out_data, out2(-1, 10));
    end
    checks++;
    if (pool_end !== 1'b1) begin failures++; $display("FAIL bp_pool_end got=%0b exp=1", pool_end); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || pool_end !== 1'b0) begin
      failures++; $display("FAIL bp_final_drain valid=%0b end=%0b exp=0/0", out_valid, pool_end);
    end
  endtask

  task automatic test_frame();
    do_reset();
    mode = 1'b0;
    for (int p = 0; p < 4; p++) begin
      push(row4(2*p, 2*p, 2*p, 2*p));
      push(row4(2*p+1, 2*p+1, 2*p+1, 2*p+1));
      checks++;
      if (out_valid !== 1'b1 || out_data !== out2(2*p+1, 2*p+1)) begin
        failures++; $display("FAIL frame_data p=%0d valid=%0b data=%h exp=1/%h", p, out_valid, out_data, out2(2*p+1, 2*p+1));
      end
      checks++;
      if (pool_end !== ((p % 2) == 1)) begin
        failures++; $display("FAIL frame_pool_end p=%0d got=%0b exp=%0b", p, pool_end, (p % 2) == 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    mode = 1'b0;
    push(row4(100, 100, 100, 100));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(row4(1, 1, 1, 1));
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_early got=%0b exp=0", out_valid); end
    push(row4(2, 3, 4, 5));
    checks++;
    if (out_valid !== 1'b1 || out_data !== out2(3, 5)) begin
      failures++; $display("FAIL rstmid_data valid=%0b data=%h exp=1/%h", out_valid, out_data, out2(3, 5));
    end
    checks++;
    if (pool_end !== 1'b0) begin failures++; $display("FAIL rstmid_pool_end got=%0b exp=0", pool_end); end
  endtask

  task automatic test_enable();
    do_reset();
    mode      = 1'b0;
    out_ready = 1'b0;
    push(row4(1, 2, 3, 4));
    push(row4(0, 0, 0, 0));
    en       = 1'b0;
    in_data  = row4(-5, -6, -7, -8);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL en_in_ready got=%0b exp=0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL en_drain got=%0b exp=0", out_valid); end
    @(negedge clk);
    en = 1'b1;
    push(row4(-5, -6, -7, -8));
    push(row4(-1, -9, 10, -10));
    checks++;
    if (out_data !== out2(-1, 10)) begin failures++; $display("FAIL en_resume got=%h exp=%h", out_data, out2(-1, 10)); end
    checks++;
    if (pool_end !== 1'b1) begin failures++; $display("FAIL en_pool_end got=%0b exp=1", pool_end); end
  endtask

  task automatic test_relu_mode_latch();
    logic [15:0] exp;
`ifdef POOL2X2_RELU_EN
    exp = out2(0, 0);
`else
    exp = out2(-1, -20);
`endif
    do_reset();
    mode = 1'b0;
    push(row4(-3, -5, -20, -20));
    mode = 1'b1;
    push(row4(-1, -8, -20, -20));
    checks++;
    if (out_data !== exp) begin failures++; $display("FAIL relu_latched_mode got=%h exp=%h", out_data, exp); end
    mode = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_max();
    test_avg();
    test_backpressure();
    test_frame();
    test_reset_mid_frame();
    test_enable();
    test_relu_mode_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
